led_fade_ctrl: RTL and testbench

LED_FADE_CTRL -- requirements
Module: led_fade_ctrl

---
 rtl/led_fade_pkg.sv | 17 +
 rtl/fade_tick_gen.sv | 45 ++++
 rtl/led_fade_ctrl.sv | 150 +++++++++++++++
 tb/tb_led_fade_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_fade_pkg.sv
// led_fade_pkg
// Shared constants and types for the LED fade controller.
//   LEVEL_W      : brightness width (PWM level input width)
//   RATE_W       : width of the step-period multiplier
//   fade_state_e : fade controller state (IDLE, UP, DOWN)
package led_fade_pkg;

    localparam int unsigned LEVEL_W = 8;
    localparam int unsigned RATE_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } fade_state_e;

endpackage

// File: rtl/fade_tick_gen.sv
// fade_tick_gen
// Step prescaler: issues one step pulse every `period` cycles while enabled.
// Ports:
//   clk    : clock
//   rst    : asynchronous active-high reset
//   clear  : restart the count from zero (a new command was accepted)
//   enable : count while high; the counter holds at zero while low
//   period : cycles per step (>= 2)
//   step   : one-cycle pulse; the consumer acts on the edge ending it
module fade_tick_gen #(
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                step
);

    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;

    // With the count cleared on accept edge A, the count reaches period-1
    // after edge A+period-1, so the consumer's update lands on edge A+period.
    assign step = enable && !clear && (cnt_q == period - PERIOD_W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable || step) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_fade_ctrl.sv
// led_fade_ctrl
// Ramps an 8-bit LED brightness up or down one step at a time toward a
// commanded target, or oscillates between 0 and the target (breathe).
// Ports:
//   clk         : clock
//   rst         : asynchronous active-high reset
//   cmd_valid   : a fade command is offered
//   cmd_ready   : a command is accepted this cycle (idle or breathing)
//   cmd_target  : final / peak brightness
//   cmd_rate    : step period = (cmd_rate+1)*TICK_DIV cycles
//   cmd_breathe : oscillate 0<->target until the next accepted command
//   level       : registered brightness for the PWM generator
//   busy        : a ramp or breathe is in progress
//   done        : one-cycle pulse when a non-breathe ramp completes
module led_fade_ctrl
    import led_fade_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [LEVEL_W-1:0] cmd_target,
    input  logic [RATE_W-1:0]  cmd_rate,
    input  logic               cmd_breathe,
    output logic [LEVEL_W-1:0] level,
    output logic               busy,
    output logic               done
);

    localparam int unsigned PERIOD_W = $clog2((1 << RATE_W) * TICK_DIV + 1);

    fade_state_e        state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LEVEL_W-1:0] target_q, target_d;
    logic [RATE_W-1:0]  rate_q, rate_d;
    logic               breathe_q, breathe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               done_pend_q, done_pend_d;

    logic                accept;
    logic                step;
    logic                tick_en;
    logic [PERIOD_W-1:0] period;

    assign cmd_ready = (state_q == IDLE) || breathe_q;
    assign accept    = cmd_valid && cmd_ready;
    assign tick_en   = (state_q == UP) || (state_q == DOWN);
    assign period    = PERIOD_W'((32'(rate_q) + 32'd1) * TICK_DIV);

    fade_tick_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (tick_en),
        .period (period),
        .step   (step)
    );

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        target_d    = target_q;
        rate_d      = rate_q;
        breathe_d   = breathe_q;
        // An equal-target command reports done one edge after acceptance.
        done_d      = done_pend_q;
        done_pend_d = 1'b0;

        if (accept) begin
            // A new command wins over a coincident step: restart from level_q.
            target_d  = cmd_target;
            rate_d    = cmd_rate;
            // Breathing toward 0 has nothing to oscillate over.
            breathe_d = cmd_breathe && (cmd_target != '0);
            if (cmd_target > level_q) begin
                state_d = UP;
            end else if (cmd_target < level_q) begin
                state_d = DOWN;
            end else if (breathe_d) begin
                // Already at the peak: start the swing downward.
                state_d = DOWN;
            end else begin
                state_d     = IDLE;
                done_pend_d = 1'b1;
            end
        end else if (step) begin
            unique case (state_q)
                UP: begin
                    level_d = level_q + LEVEL_W'(1);
                    if (level_d == target_q) begin
                        if (breathe_q) begin
                            state_d = DOWN;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                DOWN: begin
                    level_d = level_q - LEVEL_W'(1);
                    if (breathe_q) begin
                        // Breathing passes through the target; only 0 reverses.
                        if (level_d == '0) begin
                            state_d = UP;
                        end
                    end else if (level_d == target_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        busy_d = (state_d == UP) || (state_d == DOWN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            level_q     <= '0;
            target_q    <= '0;
            rate_q      <= '0;
            breathe_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            target_q    <= target_d;
            rate_q      <= rate_d;
            breathe_q   <= breathe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_pend_q <= done_pend_d;
        end
    end

    assign level = level_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_led_fade_ctrl.sv
// tb_led_fade_ctrl
// Drives directed and random fade commands into led_fade_ctrl (TICK_DIV=4)
// and compares level/busy/done/cmd_ready every cycle with a trajectory
// model: each accepted command defines a segment whose outputs are a
// closed-form function of the cycles elapsed since acceptance.
module tb_led_fade_ctrl;

    localparam int TDIV = 4;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_target;
    logic [3:0] cmd_rate;
    logic       cmd_breathe;
    logic [7:0] level;
    logic       busy;
    logic       done;

    led_fade_ctrl #(
        .TICK_DIV (TDIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_target  (cmd_target),
        .cmd_rate    (cmd_rate),
        .cmd_breathe (cmd_breathe),
        .level       (level),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: the current segment and the cycle counter (posedges).
    int cyc         = 0;
    int seg_a       = 0;
    int seg_s       = 0;
    int seg_t       = 0;
    int seg_p       = TDIV;
    bit seg_br      = 1'b0;
    int eq_done_cyc = -1;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int tri_wave(input int k, input int peak);
        int m;
        m = k % (2 * peak);
        return (m <= peak) ? m : 2 * peak - m;
    endfunction

    function automatic int m_level(input int c);
        int k;
        k = (c - seg_a) / seg_p;
        if (!seg_br) begin
            if (seg_t >= seg_s) return seg_s + ((k < seg_t - seg_s) ? k : seg_t - seg_s);
            else                return seg_s - ((k < seg_s - seg_t) ? k : seg_s - seg_t);
        end
        if (seg_s < seg_t) return tri_wave(seg_s + k, seg_t);
        if (k <= seg_s)    return seg_s - k;
        return tri_wave(k - seg_s, seg_t);
    endfunction

    function automatic int m_dist();
        return (seg_t >= seg_s) ? seg_t - seg_s : seg_s - seg_t;
    endfunction

    function automatic bit m_busy(input int c);
        if (seg_br) return 1'b1;
        return (c - seg_a) < m_dist() * seg_p;
    endfunction

    function automatic bit m_done(input int c);
        if (c == eq_done_cyc) return 1'b1;
        return !seg_br && (m_dist() > 0) && ((c - seg_a) == m_dist() * seg_p);
    endfunction

    function automatic bit m_ready(input int c);
        return seg_br || !m_busy(c);
    endfunction

    task automatic m_reset();
        seg_a       = cyc;
        seg_s       = 0;
        seg_t       = 0;
        seg_p       = TDIV;
        seg_br      = 1'b0;
        eq_done_cyc = -1;
    endtask

    // One clock cycle: offer inputs, take the edge, update the model, check.
    task automatic tick(input bit v, input int tg, input int rt, input bit br);
        int cur;
        bit acc;
        cur         = m_level(cyc);
        acc         = v && m_ready(cyc);
        cmd_valid   = v;
        cmd_target  = tg[7:0];
        cmd_rate    = rt[3:0];
        cmd_breathe = br;
        @(posedge clk);
        cyc++;
        #1 cmd_valid = 1'b0;
        if (acc) begin
            seg_a  = cyc;
            seg_s  = cur;
            seg_t  = tg;
            seg_p  = (rt + 1) * TDIV;
            seg_br = br && (tg != 0);
            if (!seg_br && tg == cur) eq_done_cyc = cyc + 1;
        end
        @(negedge clk);
        check_val("level", level, m_level(cyc));
        check_val("busy", busy, m_busy(cyc));
        check_val("done", done, m_done(cyc));
        check_val("cmd_ready", cmd_ready, m_ready(cyc));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 1'b0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 5000 && m_busy(cyc); i++) tick(1'b0, 0, 0, 1'b0);
        idle(2);
    endtask

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_target  = '0;
        cmd_rate    = '0;
        cmd_breathe = 1'b0;
        #1;
        check_val("rst_level", level, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_ready", cmd_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        m_reset();

        // Up ramp, then down ramp at rate 1.
        tick(1'b1, 3, 0, 1'b0);
        wait_idle();
        check_val("up_final", level, 3);
        tick(1'b1, 1, 1, 1'b0);
        wait_idle();
        check_val("down_final", level, 1);

        // Equal target: done one cycle after accept, no motion.
        tick(1'b1, 5, 0, 1'b0);
        wait_idle();
        tick(1'b1, 5, 2, 1'b0);
        idle(3);
        tick(1'b1, 0, 0, 1'b0);
        wait_idle();

        // Breathe, then preempt 44 cycles after acceptance.
        tick(1'b1, 2, 1, 1'b1);
        idle(43);
        tick(1'b1, 0, 0, 1'b0);
        wait_idle();
        check_val("preempt_final", level, 0);

        // A command offered mid-ramp is dropped.
        tick(1'b1, 6, 0, 1'b0);
        idle(5);
        repeat (3) tick(1'b1, 200, 0, 1'b0);
        wait_idle();
        check_val("reject_final", level, 6);

        // Breathe toward 0 acts as a plain ramp; at 0 it is an equal target.
        tick(1'b1, 0, 3, 1'b1);
        wait_idle();
        tick(1'b1, 0, 0, 1'b1);
        idle(3);

        // Reset asserted mid-ramp takes effect without a clock edge.
        tick(1'b1, 9, 0, 1'b0);
        idle(10);
        #2 rst = 1'b1;
        #1;
        check_val("async_level", level, 0);
        check_val("async_busy", busy, 0);
        check_val("async_done", done, 0);
        check_val("async_ready", cmd_ready, 1);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        #1 check_val("post_rst_ready", cmd_ready, 1);
        idle(2);

        // Random commands, including ones offered while not ready.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                tick(1'b1, int'($urandom_range(0, 10)), int'($urandom_range(0, 3)),
                     $urandom_range(0, 2) == 0);
            end else begin
                tick(1'b0, 0, 0, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
